// File: rtl/call_return_ctrl_if.sv
// Bundle between decode/PC/stack and call_return_ctrl.
// master: decode, PC register and stack side; slave: the controller.
interface call_return_ctrl_if;
    logic       call;
    logic       ret;
    logic [7:0] pc;
    logic [7:0] target;
    logic [7:0] stack_data;
    logic       stack_push;
    logic       stack_pop;
    logic [7:0] stack_value;
    logic       pc_load;
    logic [7:0] pc_next;
    logic       busy;
    logic [3:0] depth;
    logic       overflow;
    logic       underflow;

    modport master (
        output call, ret, pc, target, stack_data,
        input  stack_push, stack_pop, stack_value, pc_load, pc_next, busy, depth,
        input  overflow, underflow
    );

    modport slave (
        input  call, ret, pc, target, stack_data,
        output stack_push, stack_pop, stack_value, pc_load, pc_next, busy, depth,
        output overflow, underflow
    );
endinterface

// File: rtl/call_return_ctrl.sv
// CALL/RET control in front of the 15-entry hardware stack: push/pop strobes, PC redirects.
// Define CALL_RET_BYPASS_EN for single-cycle RET (no RET_WB state, busy tied low).
module call_return_ctrl #(
    parameter int unsigned DEPTH       = 15,
    parameter int unsigned INSTR_BYTES = 4
) (
    input logic             clk,
    input logic             rst,
    call_return_ctrl_if.slave bus
);
    localparam logic [3:0] DepthMax = 4'(DEPTH);
    localparam logic [7:0] InstrInc = 8'(INSTR_BYTES);

    logic [3:0] depth_q;
    logic       overflow_q;
    logic       underflow_q;
    logic       idle;

`ifndef CALL_RET_BYPASS_EN
    typedef enum logic [0:0] {StIdle, StRetWb} state_e;
    state_e     state_q;
    logic [7:0] ret_addr_q;

    assign idle = (state_q == StIdle);
`else
    assign idle = 1'b1;
`endif

    logic accept_call;
    logic accept_ret;
    logic call_ok;
    logic ret_ok;

    // CALL wins over a simultaneous RET; the ignored RET raises no flag.
    always_comb begin
        accept_call = idle && bus.call;
        accept_ret  = idle && bus.ret && !bus.call;
        call_ok     = accept_call && (depth_q < DepthMax);
        ret_ok      = accept_ret && (depth_q != 4'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            depth_q     <= 4'd0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
`ifndef CALL_RET_BYPASS_EN
            state_q     <= StIdle;
            ret_addr_q  <= 8'h00;
`endif
        end else begin
            if (call_ok) begin
                depth_q <= depth_q + 4'd1;
            end else if (ret_ok) begin
                depth_q <= depth_q - 4'd1;
            end
            if (accept_call && !call_ok) begin
                overflow_q <= 1'b1;
            end
            if (accept_ret && !ret_ok) begin
                underflow_q <= 1'b1;
            end
`ifndef CALL_RET_BYPASS_EN
            if (state_q == StRetWb) begin
                state_q <= StIdle;
            end else if (ret_ok) begin
                ret_addr_q <= bus.stack_data;
                state_q    <= StRetWb;
            end
`endif
        end
    end

    always_comb begin
        bus.stack_push  = 1'b0;
        bus.stack_pop   = 1'b0;
        bus.stack_value = 8'h00;
        bus.pc_load     = 1'b0;
        bus.pc_next     = 8'h00;
        bus.busy        = 1'b0;
        // Strobes are held low while reset is asserted so nothing leaks into the stack.
        if (!rst) begin
            if (call_ok) begin
                bus.stack_push  = 1'b1;
                bus.stack_value = bus.pc + InstrInc;
                bus.pc_load     = 1'b1;
                bus.pc_next     = bus.target;
            end
            if (ret_ok) begin
                bus.stack_pop = 1'b1;
`ifdef CALL_RET_BYPASS_EN
                bus.pc_load   = 1'b1;
                bus.pc_next   = bus.stack_data;
`endif
            end
`ifndef CALL_RET_BYPASS_EN
            if (state_q == StRetWb) begin
                bus.busy    = 1'b1;
                bus.pc_load = 1'b1;
                bus.pc_next = ret_addr_q;
            end
`endif
        end
    end

    assign bus.depth     = depth_q;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
endmodule

// File: tb/tb_call_return_ctrl.sv
// Bench for call_return_ctrl: directed steps then random traffic against a queue-based stack model.
// Honours CALL_RET_BYPASS_EN for single-cycle RET expectations.
module tb_call_return_ctrl;
`ifdef CALL_RET_BYPASS_EN
    localparam bit Bypass = 1'b1;
`else
    localparam bit Bypass = 1'b0;
`endif

    logic clk;
    logic rst;
    call_return_ctrl_if bus ();

    call_return_ctrl #(
        .DEPTH      (15),
        .INSTR_BYTES(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    // Model: the hardware stack itself, flags, and a pending RET redirect.
    logic [7:0] stk[$];
    bit         m_ovf;
    bit         m_unf;
    bit         pend;
    logic [7:0] pend_addr;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic c, input logic rt,
                        input logic [7:0] p, input logic [7:0] tg);
        logic       e_push, e_pop, e_load, e_busy;
        logic [7:0] e_val, e_next;
        int         sz;
        sz = stk.size();
        rst            = r;
        bus.call       = c;
        bus.ret        = rt;
        bus.pc         = p;
        bus.target     = tg;
        bus.stack_data = (sz > 0) ? stk[sz-1] : 8'($urandom);
        e_push = 1'b0; e_pop = 1'b0; e_load = 1'b0; e_busy = 1'b0;
        e_val  = 8'h00; e_next = 8'h00;
        if (!r) begin
            if (pend) begin
                e_busy = 1'b1; e_load = 1'b1; e_next = pend_addr;
            end else if (c) begin
                if (sz < 15) begin
                    e_push = 1'b1; e_val = p + 8'd4; e_load = 1'b1; e_next = tg;
                end
            end else if (rt && sz > 0) begin
                e_pop = 1'b1;
                if (Bypass) begin
                    e_load = 1'b1; e_next = stk[sz-1];
                end
            end
        end
        @(negedge clk);
        chk("stack_push",  8'(bus.stack_push), 8'(e_push));
        chk("stack_pop",   8'(bus.stack_pop),  8'(e_pop));
        chk("stack_value", bus.stack_value,    e_val);
        chk("pc_load",     8'(bus.pc_load),    8'(e_load));
        chk("pc_next",     bus.pc_next,        e_next);
        chk("busy",        8'(bus.busy),       8'(e_busy));
        @(posedge clk);
        #1;
        if (r) begin
            stk.delete();
            m_ovf = 1'b0; m_unf = 1'b0; pend = 1'b0;
        end else if (pend) begin
            pend = 1'b0;
        end else if (c) begin
            if (sz < 15) stk.push_back(p + 8'd4);
            else m_ovf = 1'b1;
        end else if (rt) begin
            if (sz > 0) begin
                if (!Bypass) begin
                    pend = 1'b1; pend_addr = stk[sz-1];
                end
                void'(stk.pop_back());
            end else begin
                m_unf = 1'b1;
            end
        end
        chk("depth",     8'(bus.depth),     8'(stk.size()));
        chk("overflow",  8'(bus.overflow),  8'(m_ovf));
        chk("underflow", 8'(bus.underflow), 8'(m_unf));
    endtask

    initial begin
        m_ovf = 1'b0; m_unf = 1'b0; pend = 1'b0; pend_addr = 8'h00;
        step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        step(1'b1, 1'b1, 1'b0, 8'h10, 8'h40);
        // Basic CALL then RET with redirect.
        step(1'b0, 1'b1, 1'b0, 8'h10, 8'h40);
        step(1'b0, 1'b0, 1'b1, 8'h40, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h14, 8'h00);
        // Underflow at empty stack.
        step(1'b0, 1'b0, 1'b1, 8'h18, 8'h00);
        // CALL priority over simultaneous RET at depth 2.
        step(1'b0, 1'b1, 1'b0, 8'h00, 8'h10);
        step(1'b0, 1'b1, 1'b0, 8'h10, 8'h20);
        step(1'b0, 1'b1, 1'b1, 8'h20, 8'h80);
        // call/ret presented during RET_WB must be ignored.
        step(1'b0, 1'b0, 1'b1, 8'h80, 8'h00);
        step(1'b0, 1'b1, 1'b1, 8'h30, 8'h90);
        step(1'b0, 1'b0, 1'b0, 8'h34, 8'h00);
        // Fill past capacity; overflow must survive later RETs.
        repeat (16) step(1'b0, 1'b1, 1'b0, 8'($urandom), 8'($urandom));
        step(1'b0, 1'b1, 1'b0, 8'h50, 8'h60);
        step(1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        step(1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        // Wrap of return address, then reset landing on RET_WB.
        step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        step(1'b0, 1'b1, 1'b0, 8'hFC, 8'h08);
        step(1'b0, 1'b0, 1'b1, 8'h08, 8'h00);
        step(1'b1, 1'b0, 1'b0, 8'h0C, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            logic r, c, rt;
            r  = ($urandom_range(0, 59) == 0);
            c  = ($urandom_range(0, 99) < 45);
            rt = ($urandom_range(0, 99) < 40);
            step(r, c, rt, 8'($urandom), 8'($urandom));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
